pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Pipeline sequencer for the five-stage MIPS datapath. It works alongside the short-circuit (forwarding) unit and covers what forwarding cannot resolve: load-use stalls, IF/ID flush on taken jumps/branches, and HALT draining. It also gates pipeline advance for debug-unit run and single-step commands. All pipeline-register and PC enables come from this block.

## Interface
- `REG_ADDR_SIZE`, default 5: register address width.
- `DRAIN_CYCLES`, default 3: cycles spent draining the EX/MEM/WB stages after HALT.

- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_du_run` in 1: debug unit, start continuous execution (level sampled each cycle).
- `i_du_step` in 1: debug unit, execute one pipeline cycle.
- `i_id_ex_mem_rd` in 1: the instruction in EX is a load.
- `i_id_ex_rt` in REG_ADDR_SIZE: load destination register in EX.
- `i_if_id_rs` in REG_ADDR_SIZE: source register rs of the instruction in ID.
- `i_if_id_rt` in REG_ADDR_SIZE: source register rt of the instruction in ID.
- `i_if_id_uses_rt` in 1: the instruction in ID reads rt.
- `i_id_jump` in 1: a taken jump/branch is resolved in ID this cycle.
- `i_id_halt` in 1: a HALT is decoded in ID.
- `o_pc_en` out 1: PC write enable.
- `o_if_id_en` out 1: IF/ID register write enable.
- `o_if_id_flush` out 1: load a NOP into IF/ID.
- `o_id_ex_bubble` out 1: load a NOP into ID/EX.
- `o_stage_en` out 1: enables ID/EX, EX/MEM, MEM/WB registers, register-file and data-memory writes.
- `o_halted` out 1: program finished.
- `o_busy` out 1: state is RUN, STEP or DRAIN.

## Operation
- States: IDLE (reset), RUN, STEP, DRAIN, HALTED. The state register and the 2-bit-minimum drain counter are registered; outputs are combinational from the state and the current hazard inputs.
- IDLE:
  - All outputs are 0.
  - `i_du_run` → RUN. Otherwise `i_du_step` → STEP. If both are asserted, run wins.
- RUN / STEP, active cycle: `o_stage_en`=1; hazards are evaluated in priority order:
  1. Load-use: `i_id_ex_mem_rd` && `i_id_ex_rt`≠0 && (`i_id_ex_rt`==`i_if_id_rs` || (`i_if_id_uses_rt` && `i_id_ex_rt`==`i_if_id_rt`)) → `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_bubble`=1, flush 0. `i_id_jump` and `i_id_halt` are ignored this cycle.
  2. Halt: `i_id_halt` → `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_bubble`=1; next state DRAIN with counter cleared to 0.
  3. Jump: `i_id_jump` → `o_pc_en`=1, `o_if_id_en`=1, `o_if_id_flush`=1.
  4. None: `o_pc_en`=1, `o_if_id_en`=1, bubble 0, flush 0.
- RUN stays in RUN unless it moves to DRAIN. `i_du_run` and `i_du_step` are ignored while in RUN.
- STEP lasts exactly one cycle, then returns to IDLE (or goes to DRAIN on halt). A step pulse during STEP is ignored.
- DRAIN:
  - `o_stage_en`=1, `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_bubble`=1, flush 0.
  - The counter increments each cycle. When the counter equals DRAIN_CYCLES−1 → HALTED, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - Drain runs autonomously, even when entered from STEP. Debug inputs are ignored.
- HALTED: `o_halted`=1 and all other outputs are 0. Only reset leaves this state.
- `o_busy` = 1 in RUN, STEP and DRAIN.

## Timing
- Reset (any time, including mid-DRAIN or mid-STEP): immediately IDLE, counter 0. All outputs 0, including `o_halted`=0 and `o_busy`=0.
- Command latency: a `i_du_step` sampled high in IDLE at edge n gives `o_stage_en`=1 in cycle n+1 only. `i_du_run` behaves the same way, with enables continuing from n+1.
- Hazard response is same-cycle (combinational on ID/EX and IF/ID fields). A load-use stall lasts one cycle when the inputs update normally.
- HALT at cycle h: stall outputs in h; DRAIN in h+1 … h+DRAIN_CYCLES; `o_halted`=1 from h+DRAIN_CYCLES+1.
- Register 0 never causes a stall.

## Test plan
- Reset, then one `i_du_step` pulse → exactly one cycle of `o_stage_en`=`o_pc_en`=1, then all outputs 0 in IDLE.
- RUN with `i_id_ex_mem_rd`=1, `i_id_ex_rt`=7, `i_if_id_rs`=7 → `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_bubble`=1. Repeat with rt=0 → no stall.
- RUN with `i_id_jump`=1 plus a load-use on rt (`i_if_id_uses_rt`=1, rt=5) → stall only, `o_if_id_flush`=0. Next cycle, jump only → `o_if_id_flush`=1, `o_pc_en`=1.
- RUN, `i_id_halt`=1 at cycle h → DRAIN for 3 cycles (`o_busy`=1, `o_pc_en`=0), then `o_halted`=1. Run/step pulses afterwards have no effect.
- Assert `i_reset` in the 2nd DRAIN cycle → all outputs 0 immediately. A following `i_du_run` restarts RUN.
- `i_du_run` and `i_du_step` asserted together in IDLE → RUN (enables persist beyond one cycle).

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: load-use stall, IF/ID flush on jump, HALT drain, debug run/step gating.
// Latency: hazard responses are combinational (same cycle); run/step commands act from the next cycle.
// Backpressure: stalls hold PC and IF/ID while bubbling ID/EX; drain freezes fetch until HALTED.
// Ports: i_clk, i_reset (async, high); i_du_run / i_du_step debug commands;
//        i_id_ex_* / i_if_id_* hazard fields, i_id_jump, i_id_halt;
//        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_bubble, o_stage_en, o_halted, o_busy.
module pipeline_sequencer #(
    parameter int REG_ADDR_SIZE = 5,
    parameter int DRAIN_CYCLES  = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_du_run,
    input  logic                     i_du_step,
    input  logic                     i_id_ex_mem_rd,
    input  logic [REG_ADDR_SIZE-1:0] i_id_ex_rt,
    input  logic [REG_ADDR_SIZE-1:0] i_if_id_rs,
    input  logic [REG_ADDR_SIZE-1:0] i_if_id_rt,
    input  logic                     i_if_id_uses_rt,
    input  logic                     i_id_jump,
    input  logic                     i_id_halt,
    output logic                     o_pc_en,
    output logic                     o_if_id_en,
    output logic                     o_if_id_flush,
    output logic                     o_id_ex_bubble,
    output logic                     o_stage_en,
    output logic                     o_halted,
    output logic                     o_busy
);

    // Counter is at least 2 bits wide even for tiny drain lengths.
    localparam int CNT_W = ($clog2(DRAIN_CYCLES) > 2) ? $clog2(DRAIN_CYCLES) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] drain_cnt, drain_cnt_nxt;
    logic             load_use;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = i_id_ex_mem_rd && (i_id_ex_rt != '0) &&
                      ((i_id_ex_rt == i_if_id_rs) ||
                       (i_if_id_uses_rt && (i_id_ex_rt == i_if_id_rt)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_stage_en     = 1'b0;
        o_halted       = 1'b0;
        o_busy         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_du_run) begin
                    state_nxt = ST_RUN;
                end else if (i_du_step) begin
                    state_nxt = ST_STEP;
                end
            end

            ST_RUN, ST_STEP: begin
                o_stage_en = 1'b1;
                o_busy     = 1'b1;
                // A step is a single active cycle; run persists.
                state_nxt  = (state == ST_STEP) ? ST_IDLE : ST_RUN;
                if (load_use) begin
                    // Stall wins over halt/jump: the ID instruction is re-evaluated next cycle.
                    o_id_ex_bubble = 1'b1;
                end else if (i_id_halt) begin
                    o_id_ex_bubble = 1'b1;
                    state_nxt      = ST_DRAIN;
                    drain_cnt_nxt  = '0;
                end else if (i_id_jump) begin
                    o_pc_en       = 1'b1;
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = 1'b1;
                end else begin
                    o_pc_en    = 1'b1;
                    o_if_id_en = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Older instructions finish through EX/MEM/WB while fetch stays frozen.
                o_stage_en     = 1'b1;
                o_id_ex_bubble = 1'b1;
                o_busy         = 1'b1;
                drain_cnt_nxt  = drain_cnt + 1'b1;
                if (drain_cnt == CNT_LAST) begin
                    state_nxt = ST_HALTED;
                end
            end

            ST_HALTED: begin
                o_halted = 1'b1;
            end

            default: begin
                state_nxt     = ST_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: table of hazard vectors applied in RUN,
// plus hand-written step, halt/drain, reset-in-drain and run+step sequences.
// Outputs are compared as {pc_en, if_id_en, flush, bubble, stage_en, halted, busy}.
module tb_pipeline_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       du_run, du_step, mem_rd, uses_rt, jump, halt;
    logic [4:0] ex_rt, rs, rt;
    logic       pc_en, if_id_en, if_id_flush, id_ex_bubble, stage_en, halted, busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_sequencer #(.REG_ADDR_SIZE(5), .DRAIN_CYCLES(3)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_du_run        (du_run),
        .i_du_step       (du_step),
        .i_id_ex_mem_rd  (mem_rd),
        .i_id_ex_rt      (ex_rt),
        .i_if_id_rs      (rs),
        .i_if_id_rt      (rt),
        .i_if_id_uses_rt (uses_rt),
        .i_id_jump       (jump),
        .i_id_halt       (halt),
        .o_pc_en         (pc_en),
        .o_if_id_en      (if_id_en),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_bubble  (id_ex_bubble),
        .o_stage_en      (stage_en),
        .o_halted        (halted),
        .o_busy          (busy)
    );

    // Expected output patterns
    localparam logic [6:0] O_ZERO  = 7'b0000000;
    localparam logic [6:0] O_RUN   = 7'b1100101;
    localparam logic [6:0] O_JUMP  = 7'b1110101;
    localparam logic [6:0] O_STALL = 7'b0001101;  // load-use, halt cycle and drain
    localparam logic [6:0] O_HALT  = 7'b0000010;

    typedef struct {
        logic       mem_rd;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       halt;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, stage_en, halted, busy};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clear_in();
        du_run = 0; du_step = 0; mem_rd = 0; uses_rt = 0; jump = 0; halt = 0;
        ex_rt = 0; rs = 0; rt = 0;
    endtask

    // Check mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [6:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            mem ex  rs  rt  use jmp hlt exp
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};   // no hazard
        vecs[1] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, O_STALL}; // load-use on rs
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_RUN};   // r0 never stalls
        vecs[3] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, O_STALL}; // stall beats jump
        vecs[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_JUMP};  // jump alone
        vecs[5] = '{1'b1, 5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN};   // rt match but unused
        vecs[6] = '{1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, O_RUN};   // not a load
        vecs[7] = '{1'b1, 5'd4, 5'd4, 5'd1, 1'b0, 1'b0, 1'b1, O_STALL}; // stall beats halt
        vecs[8] = '{1'b1, 5'd6, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, O_JUMP};  // load, no match, jump
        vecs[9] = '{1'b1, 5'd31,5'd1, 5'd31,1'b1, 1'b0, 1'b0, O_STALL}; // load-use on rt, r31

        clear_in();
        #2 rst = 1'b1;
        #1 check("reset_active", O_ZERO);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc("idle_after_reset", O_ZERO);

        // Single step: one active cycle, then back to IDLE.
        du_step = 1;
        cyc("idle_step_req", O_ZERO);
        du_step = 0;
        cyc("step_active", O_RUN);
        cyc("after_step", O_ZERO);
        cyc("after_step2", O_ZERO);

        // Enter RUN, then the hazard table.
        du_run = 1;
        cyc("idle_run_req", O_ZERO);
        du_run = 0;
        cyc("run_first", O_RUN);
        for (int i = 0; i < 10; i++) begin
            mem_rd  = vecs[i].mem_rd;
            ex_rt   = vecs[i].ex_rt;
            rs      = vecs[i].rs;
            rt      = vecs[i].rt;
            uses_rt = vecs[i].uses_rt;
            jump    = vecs[i].jump;
            halt    = vecs[i].halt;
            cyc($sformatf("vec%0d", i), vecs[i].exp);
        end
        clear_in();
        cyc("run_still", O_RUN);

        // HALT from RUN: stall cycle, three drain cycles, then HALTED.
        halt = 1;
        cyc("halt_cycle", O_STALL);
        halt = 0;
        cyc("drain1", O_STALL);
        cyc("drain2", O_STALL);
        cyc("drain3", O_STALL);
        cyc("halted", O_HALT);
        du_run = 1;
        cyc("halted_run_ignored", O_HALT);
        du_run = 0;
        du_step = 1;
        cyc("halted_step_ignored", O_HALT);
        du_step = 0;
        cyc("halted_hold", O_HALT);

        // Reset during the second drain cycle, then restart.
        do_reset();
        du_run = 1;
        cyc("idle_run_req2", O_ZERO);
        du_run = 0;
        halt = 1;
        cyc("halt_cycle2", O_STALL);
        halt = 0;
        cyc("drain1_b", O_STALL);
        check("drain2_b", O_STALL);
        rst = 1'b1;
        #1 check("reset_mid_drain", O_ZERO);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("idle_after_drain_reset", O_ZERO);
        du_run = 1;
        cyc("idle_run_req3", O_ZERO);
        du_run = 0;
        cyc("rerun1", O_RUN);
        cyc("rerun2", O_RUN);

        // Run and step together: run wins, enables persist.
        do_reset();
        du_run = 1;
        du_step = 1;
        cyc("idle_both_req", O_ZERO);
        clear_in();
        cyc("both1", O_RUN);
        cyc("both2", O_RUN);
        cyc("both3", O_RUN);

        // HALT reached from a single step still drains on its own.
        do_reset();
        du_step = 1;
        cyc("idle_step_req2", O_ZERO);
        du_step = 0;
        halt = 1;
        cyc("step_halt", O_STALL);
        halt = 0;
        cyc("step_drain1", O_STALL);
        cyc("step_drain2", O_STALL);
        cyc("step_drain3", O_STALL);
        cyc("step_halted", O_HALT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
